// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Snapshots an N x N result matrix on start and streams the row_w x col_x
//   top-left sub-matrix out, row-major, over a valid/ready handshake.
//
// Ports
//   clk        sole clock, rising edge
//   clear_mem  synchronous active-high reset; wins over start/res_ready
//   start      snapshot res_flat/row_w/col_x and begin a stream (IDLE only)
//   row_w      result row count, legal 1..N
//   col_x      result column count, legal 1..N
//   res_flat   product matrix, element (r,c) at [(r*N+c)*DW +: DW]
//   res        current element (0 outside SEND)
//   res_valid  res holds an element
//   res_ready  consumer accepts res when res_valid is also high
//   res_last   final element of the stream
//   busy       not IDLE
//   done       one-cycle completion pulse
//   err        pulses with done when the start carried an illegal dimension

// One snapshot element: loads on capture, otherwise holds.
module matrix_result_elem_reg #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          clear_mem,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk) begin
    if (clear_mem)  q <= '0;
    else if (load)  q <= d;
  end
endmodule

module matrix_result_streamer #(
  parameter int DW = 10,
  parameter int N  = 3
) (
  input  logic              clk,
  input  logic              clear_mem,
  input  logic              start,
  input  logic [1:0]        row_w,
  input  logic [1:0]        col_x,
  input  logic [N*N*DW-1:0] res_flat,
  output logic [DW-1:0]     res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [1:0]             rows_q, cols_q;
  logic [1:0]             row_cnt, col_cnt;
  logic                   err_q;
  logic [NE-1:0][DW-1:0]  snap_q;

  logic                   capture;
  logic                   dims_bad;
  logic                   beat;
  logic                   row_end, col_end, at_last;
  logic [IW-1:0]          idx;

  // A start is only honoured in IDLE; starts in SEND/DONE are dropped.
  assign capture  = (state == IDLE) && start;
  // Zero or over-size dimensions skip streaming and report err with done.
  assign dims_bad = (row_w == 2'd0) || (col_x == 2'd0) ||
                    (int'(row_w) > N) || (int'(col_x) > N);

  assign beat    = (state == SEND) && res_ready;
  assign col_end = (col_cnt == cols_q - 2'd1);
  assign row_end = (row_cnt == rows_q - 2'd1);
  assign at_last = row_end && col_end;

  // Snapshot keeps the full N-wide row pitch, so the read index uses N
  // even when col_x is smaller.
  assign idx = IW'(row_cnt) * IW'(N) + IW'(col_cnt);

  for (genvar e = 0; e < NE; e++) begin : g_elem
    matrix_result_elem_reg #(.DW(DW)) u_elem (
      .clk       (clk),
      .clear_mem (clear_mem),
      .load      (capture),
      .d         (res_flat[e*DW +: DW]),
      .q         (snap_q[e])
    );
  end

  always_ff @(posedge clk) begin
    if (clear_mem) state <= IDLE;
    else           state <= state_nxt;
  end

  // Dimension snapshot and row/col walk. The counters are left parked on
  // the final element; the next capture re-zeroes them.
  always_ff @(posedge clk) begin
    if (clear_mem) begin
      rows_q  <= '0;
      cols_q  <= '0;
      row_cnt <= '0;
      col_cnt <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      rows_q  <= row_w;
      cols_q  <= col_x;
      row_cnt <= '0;
      col_cnt <= '0;
      err_q   <= dims_bad;
    end else if (beat && !at_last) begin
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 2'd1;
      end else begin
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    res       = '0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = dims_bad ? DONE : SEND;
      end
      SEND: begin
        res       = snap_q[idx];
        res_valid = 1'b1;
        res_last  = at_last;
        if (res_ready && at_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer: constant vector table,
// hand-written corner sequences, then random streams checked against a
// queue-based reference of the expected row-major element order.
module tb_matrix_result_streamer;
  localparam int DW = 10;
  localparam int N  = 3;
  localparam int FW = N*N*DW;

  logic          clk = 1'b0;
  logic          clear_mem, start, res_ready;
  logic [1:0]    row_w, col_x;
  logic [FW-1:0] res_flat;
  logic [DW-1:0] res;
  logic          res_valid, res_last, busy, done, err;

  int total  = 0;
  int passed = 0;

  matrix_result_streamer #(.DW(DW), .N(N)) dut (
    .clk       (clk),
    .clear_mem (clear_mem),
    .start     (start),
    .row_w     (row_w),
    .col_x     (col_x),
    .res_flat  (res_flat),
    .res       (res),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [FW-1:0] mk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [FW-1:0] f;
    f = '0;
    f[0*DW +: DW] = DW'(a0); f[1*DW +: DW] = DW'(a1); f[2*DW +: DW] = DW'(a2);
    f[3*DW +: DW] = DW'(a3); f[4*DW +: DW] = DW'(a4); f[5*DW +: DW] = DW'(a5);
    f[6*DW +: DW] = DW'(a6); f[7*DW +: DW] = DW'(a7); f[8*DW +: DW] = DW'(a8);
    return f;
  endfunction

  // Reference: the expected stream is the row-major list of the snapshot's
  // top-left rw x cx elements; each accepted beat pops the head.
  // rmode: 0 ready always, 1 random ready, 2 stall 3 cycles on beat 3.
  // disturb: scribble inputs and pulse start mid-stream / in DONE.
  task automatic run_stream(input logic [FW-1:0] flat, input logic [1:0] rw,
                            input logic [1:0] cx, input int rmode, input bit disturb);
    logic [DW-1:0] q[$];
    int  cyc, beat, stall;
    bit  legal, rdy;
    legal = (rw != 0) && (cx != 0);
    for (int r = 0; r < int'(rw); r++)
      for (int c = 0; c < int'(cx); c++)
        q.push_back(flat[(r*N + c)*DW +: DW]);
    res_flat = flat; row_w = rw; col_x = cx; res_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    if (disturb) begin res_flat = '0; row_w = 2'($urandom); col_x = 2'($urandom); end
    cyc = 0; beat = 0; stall = 0;
    while (q.size() > 0 && cyc < 200) begin
      chk("stream_valid", res_valid, 1);
      chk("stream_data", res, q[0]);
      chk("stream_last", res_last, q.size() == 1);
      chk("stream_busy", busy, 1);
      chk("stream_done", done, 0);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(beat == 3 && stall < 3);
      endcase
      if (!rdy && beat == 3) stall++;
      if (disturb) begin
        start    = (cyc == 2);
        res_flat = {3{$urandom}};
        row_w    = 2'($urandom);
        col_x    = 2'($urandom);
      end
      res_ready = rdy;
      step();
      if (rdy) begin void'(q.pop_front()); beat++; end
      cyc++;
    end
    chk("stream_drained", q.size(), 0);
    start     = disturb;
    res_ready = 1'($urandom_range(0, 1));
    chk("end_done", done, 1);
    chk("end_err", err, !legal);
    chk("end_valid", res_valid, 0);
    chk("end_busy", busy, 1);
    step();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", res_valid, 0);
    if (disturb) begin
      step();
      chk("no_queued_start", busy, 0);
    end
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]    rw;
    logic [1:0]    cx;
    logic [FW-1:0] flat;
    int            nbeats;
    logic [FW-1:0] seq;   // expected elements, element i at [i*DW +: DW]
    bit            e_err;
  } vec_t;

  initial begin
    vec_t          vecs[8];
    logic [FW-1:0] m, rf;

    m = mk9(41, 45, 49, 87, 96, 105, 125, 138, 151);
    vecs[0] = '{2'd3, 2'd3, m, 9, mk9(41, 45, 49, 87, 96, 105, 125, 138, 151), 1'b0};
    vecs[1] = '{2'd1, 2'd1, mk9(1023, 5, 5, 5, 5, 5, 5, 5, 5), 1, mk9(1023, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0};
    vecs[2] = '{2'd0, 2'd2, m, 0, '0, 1'b1};
    vecs[3] = '{2'd2, 2'd3, m, 6, mk9(41, 45, 49, 87, 96, 105, 0, 0, 0), 1'b0};
    vecs[4] = '{2'd3, 2'd1, m, 3, mk9(41, 87, 125, 0, 0, 0, 0, 0, 0), 1'b0};
    vecs[5] = '{2'd1, 2'd3, m, 3, mk9(41, 45, 49, 0, 0, 0, 0, 0, 0), 1'b0};
    vecs[6] = '{2'd2, 2'd0, m, 0, '0, 1'b1};
    vecs[7] = '{2'd2, 2'd2, m, 4, mk9(41, 45, 87, 96, 0, 0, 0, 0, 0), 1'b0};

    clear_mem = 1'b1; start = 1'b0; res_ready = 1'b0;
    row_w = 2'd0; col_x = 2'd0; res_flat = '0;
    step(); step();
    chk("rst_res", res, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_last", res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // clear_mem beats a simultaneous start
    res_flat = m; row_w = 2'd3; col_x = 2'd3; start = 1'b1; res_ready = 1'b1;
    step();
    chk("clr_prio_busy", busy, 0);
    chk("clr_prio_valid", res_valid, 0);
    clear_mem = 1'b0; start = 1'b0; res_ready = 1'b0;
    step();

    // Table: ready held high, one beat per cycle from k+1
    foreach (vecs[v]) begin
      res_flat = vecs[v].flat; row_w = vecs[v].rw; col_x = vecs[v].cx;
      res_ready = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < vecs[v].nbeats; i++) begin
        chk("tbl_valid", res_valid, 1);
        chk("tbl_data", res, vecs[v].seq[i*DW +: DW]);
        chk("tbl_last", res_last, i == vecs[v].nbeats - 1);
        step();
      end
      chk("tbl_done", done, 1);
      chk("tbl_err", err, vecs[v].e_err);
      chk("tbl_nvalid", res_valid, 0);
      step();
      chk("tbl_idle", busy, 0);
    end
    res_ready = 1'b0;

    // Stall on element 87, then snapshot isolation with ignored starts
    run_stream(m, 2'd3, 2'd3, 2, 1'b0);
    run_stream(m, 2'd3, 2'd3, 1, 1'b1);

    // Abort during element 96: no done, back to idle immediately
    res_flat = m; row_w = 2'd3; col_x = 2'd3; start = 1'b1; res_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_pre_data", res, 96);
    chk("abort_pre_valid", res_valid, 1);
    clear_mem = 1'b1;
    step();
    clear_mem = 1'b0;
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_res", res, 0);
    chk("abort_last", res_last, 0);
    repeat (3) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_no_valid", res_valid, 0);
    end
    res_ready = 1'b0;

    // Random streams
    for (int t = 0; t < 40; t++) begin
      for (int e = 0; e < N*N; e++) rf[e*DW +: DW] = DW'($urandom);
      run_stream(rf, 2'($urandom), 2'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        res_ready = 1'($urandom_range(0, 1));
        step();
        chk("gap_valid", res_valid, 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter DW, default 10, result element width in bits.
REQ-002 SHALL have parameter N, default 3, maximum matrix dimension (rows and columns).
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state updates on rising edge.
REQ-004 SHALL have port clear_mem, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, request to snapshot and stream one result matrix.
REQ-006 SHALL have port row_w, input, 2 bits, result row count (rows of W), legal 1..3.
REQ-007 SHALL have port col_x, input, 2 bits, result column count (columns of X), legal 1..3.
REQ-008 SHALL have port res_flat, input, N*N*DW bits, product matrix; element (r,c), 0-based, at bits [(r*N+c)*DW +: DW].
REQ-009 SHALL have port res, output, DW bits, current streamed element.
REQ-010 SHALL have port res_valid, output, 1 bit, res holds a valid element.
REQ-011 SHALL have port res_ready, input, 1 bit, consumer accepts res on a cycle where res_valid and res_ready are both high.
REQ-012 SHALL have port res_last, output, 1 bit, high with res_valid on the final element.
REQ-013 SHALL have port busy, output, 1 bit, high in every state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-015 SHALL have port err, output, 1 bit, one-cycle pulse coincident with done when a start had an illegal dimension.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, DONE.
REQ-017 IDLE + start: on that edge SHALL capture res_flat, row_w and col_x into internal registers, clear row/col counters to 0, go to SEND.
REQ-018 Later changes on res_flat, row_w, col_x SHALL NOT affect a stream in progress.
REQ-019 Latency: start sampled at edge k -> res_valid=1 with element (0,0) during cycle k+1.
REQ-020 SEND: res SHALL be the snapshot element (row_cnt, col_cnt) and res_valid SHALL be 1.
REQ-021 res and res_last SHALL stay stable while res_valid=1 and res_ready=0.
REQ-022 Handshake with col_cnt<col_x-1: col_cnt increments.
REQ-023 Handshake with col_cnt=col_x-1 and row_cnt<row_w-1: col_cnt wraps to 0 and row_cnt increments.
REQ-024 Order SHALL be row-major; exactly row_w*col_x elements per stream.
REQ-025 res_last SHALL be 1 iff row_cnt=row_w-1 and col_cnt=col_x-1 while in SEND.
REQ-026 Handshake on the last element SHALL go to DONE; res_valid=0 next cycle.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 start in SEND or DONE SHALL be ignored and SHALL NOT be queued.
REQ-029 start in IDLE with row_w=0 or col_x=0: SHALL go directly to DONE, emit no element, assert err=1 with done.
REQ-030 Outside SEND: res=0, res_valid=0, res_last=0.
REQ-031 res_ready while res_valid=0 SHALL have no effect.
REQ-032 Elements SHALL pass through unmodified at full DW width; no arithmetic on data.

Reset
REQ-033 clear_mem=1 at a rising edge: next state IDLE, counters and snapshot cleared, res=0, res_valid=0, res_last=0, busy=0, done=0, err=0.
REQ-034 clear_mem SHALL take priority over start and res_ready on the same edge.
REQ-035 clear_mem during SEND SHALL abort the stream: no done pulse, no further elements.

Verification
REQ-036 3x3 result bus loaded with rows {41,45,49},{87,96,105},{125,138,151}, row_w=3, col_x=3, start one cycle, res_ready=1 -> 41,45,49,87,96,105,125,138,151 on 9 consecutive cycles from k+1; res_last only with 151; done (err=0) the following cycle.
REQ-037 row_w=1, col_x=1, element (0,0)=1023 -> single beat res=1023 with res_last=1, then done.
REQ-038 3x3 stream with res_ready low for 3 cycles at element 87 -> 87 held stable with res_valid=1 for those cycles; no element skipped or repeated.
REQ-039 Start, change res_flat to all zeros the cycle after start, and pulse start again mid-stream -> stream still shows the original snapshot values; exactly one stream and one done.
REQ-040 clear_mem=1 during element 96 -> next cycle res_valid=0, busy=0, res=0; no done pulse.
REQ-041 row_w=0, col_x=2, start -> no res_valid; done=1 and err=1 in the cycle after start, then IDLE.
